// File: rtl/median_5x5_filter_if.sv
// Pixel-stream bundle between the line-buffer/window stage and the 5x5 median core:
// three flattened 25-element kernels plus strobes in, one filtered RGB pixel plus strobes out.
interface median_5x5_filter_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [25*DATA_W-1:0] kernel_red;
    logic [25*DATA_W-1:0] kernel_green;
    logic [25*DATA_W-1:0] kernel_blue;
    logic                 rx_dv;
    logic                 rx_hs;
    logic                 rx_vs;
    logic [DATA_W-1:0]    tx_red;
    logic [DATA_W-1:0]    tx_green;
    logic [DATA_W-1:0]    tx_blue;
    logic                 tx_dv;
    logic                 tx_hs;
    logic                 tx_vs;

    modport master (
        output kernel_red, kernel_green, kernel_blue, rx_dv, rx_hs, rx_vs,
        input  tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs
    );

    modport slave (
        input  kernel_red, kernel_green, kernel_blue, rx_dv, rx_hs, rx_vs,
        output tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs
    );
endinterface

// File: rtl/median_5x5_filter.sv
// Four-stage pipelined 5x5 median filter: register, precedence matrix, rank popcount, select.
// Windows not yet fully populated at line/frame start pass the centre pixel through.
module median_5x5_filter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 11,
    parameter int unsigned EDGE   = 4
) (
    input logic                clk,
    input logic                rst,
    median_5x5_filter_if.slave bus
);
    localparam int unsigned      N        = 25;
    localparam int unsigned      CENTRE   = 12;
    localparam logic [4:0]       MID_RANK = 5'd12;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] EDGE_CNT = CNT_W'(EDGE);

    typedef struct packed {
        logic win_ok;
        logic dv;
        logic hs;
        logic vs;
    } ctl_t;

    // Channel index 0 = red, 1 = green, 2 = blue.
    logic [2:0][N-1:0][DATA_W-1:0] in_v;
    logic [2:0][N-1:0][DATA_W-1:0] s1_v_q, s2_v_q, s3_v_q;
    logic [2:0][N-1:0][N-1:0]      prec_d, s2_p_q;
    logic [2:0][N-1:0][4:0]        rank_d, s3_rank_q;
    logic [2:0][DATA_W-1:0]        med_d, tx_q;
    ctl_t                          in_ctl, s1_ctl_q, s2_ctl_q, s3_ctl_q;
    logic [2:0]                    tx_strb_q;

    logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
    logic             line_seen_q, line_seen_d;
    logic             hs_q;
    logic             hs_rise;

    assign in_v = {bus.kernel_blue, bus.kernel_green, bus.kernel_red};

    always_comb begin
        hs_rise = bus.rx_hs & ~hs_q;

        col_d = col_q;
        if (bus.rx_hs) begin
            col_d = '0;
        end else if (bus.rx_dv && (col_q != CNT_MAX)) begin
            col_d = col_q + 1'b1;
        end

        row_d = row_q;
        if (bus.rx_vs) begin
            row_d = '0;
        end else if (hs_rise && line_seen_q && (row_q != CNT_MAX)) begin
            row_d = row_q + 1'b1;
        end

        line_seen_d = line_seen_q;
        if (bus.rx_vs || hs_rise) begin
            line_seen_d = 1'b0;
        end else if (bus.rx_dv) begin
            line_seen_d = 1'b1;
        end

        // Window fullness is judged on the counters as they stood before this pixel.
        in_ctl.win_ok = (col_q >= EDGE_CNT) && (row_q >= EDGE_CNT);
        in_ctl.dv     = bus.rx_dv;
        in_ctl.hs     = bus.rx_hs;
        in_ctl.vs     = bus.rx_vs;
    end

    // Index tie-break makes the precedence a strict total order, so ranks are a permutation.
    always_comb begin
        prec_d = '0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    prec_d[c][i][j] = (s1_v_q[c][j] < s1_v_q[c][i]) ||
                                      ((s1_v_q[c][j] == s1_v_q[c][i]) && (j < i));
                end
            end
        end
    end

    always_comb begin
        rank_d = '0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    rank_d[c][i] = rank_d[c][i] + {4'b0000, s2_p_q[c][i][j]};
                end
            end
        end
    end

    always_comb begin
        med_d = '0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) begin
                if (s3_rank_q[c][i] == MID_RANK) begin
                    med_d[c] = med_d[c] | s3_v_q[c][i];
                end
            end
            if (!s3_ctl_q.win_ok) begin
                med_d[c] = s3_v_q[c][CENTRE];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            line_seen_q <= 1'b0;
            hs_q        <= 1'b0;
            s1_v_q      <= '0;
            s2_v_q      <= '0;
            s3_v_q      <= '0;
            s2_p_q      <= '0;
            s3_rank_q   <= '0;
            s1_ctl_q    <= '0;
            s2_ctl_q    <= '0;
            s3_ctl_q    <= '0;
            tx_q        <= '0;
            tx_strb_q   <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            line_seen_q <= line_seen_d;
            hs_q        <= bus.rx_hs;
            s1_v_q      <= in_v;
            s2_v_q      <= s1_v_q;
            s3_v_q      <= s2_v_q;
            s2_p_q      <= prec_d;
            s3_rank_q   <= rank_d;
            s1_ctl_q    <= in_ctl;
            s2_ctl_q    <= s1_ctl_q;
            s3_ctl_q    <= s2_ctl_q;
            tx_q        <= med_d;
            tx_strb_q   <= {s3_ctl_q.dv, s3_ctl_q.hs, s3_ctl_q.vs};
        end
    end

    assign bus.tx_red   = tx_q[0];
    assign bus.tx_green = tx_q[1];
    assign bus.tx_blue  = tx_q[2];
    assign bus.tx_dv    = tx_strb_q[2];
    assign bus.tx_hs    = tx_strb_q[1];
    assign bus.tx_vs    = tx_strb_q[0];
endmodule

// File: tb/tb_median_5x5_filter.sv
// Bench for median_5x5_filter: framed pixel stream with random and directed kernels,
// checked against a sort-based median model and the frame geometry the bench generates.
module tb_median_5x5_filter;
    localparam int unsigned DATA_W = 8;
    localparam int          LINES  = 6;
    localparam int          WIDTH  = 8;

    typedef logic [DATA_W-1:0] pix_t;
    typedef struct packed {
        logic dv;
        logic hs;
        logic vs;
        pix_t r;
        pix_t g;
        pix_t b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    median_5x5_filter_if #(.DATA_W(DATA_W)) bus ();

    median_5x5_filter #(
        .DATA_W(DATA_W),
        .CNT_W (11),
        .EDGE  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    pix_t k[3][25];

    function automatic pix_t median_of(input int c);
        pix_t s[$];
        for (int i = 0; i < 25; i++) s.push_back(k[c][i]);
        s.sort();
        return s[12];
    endfunction

    task automatic shuffle(input int c);
        for (int i = 24; i > 0; i--) begin
            int   j;
            pix_t t;
            j       = $urandom_range(0, i);
            t       = k[c][i];
            k[c][i] = k[c][j];
            k[c][j] = t;
        end
    endtask

    // 0 random, 1 flat 0x55, 2 permutations of 0..24, 3 impulse/tie cases, 4 heavy duplicates.
    task automatic gen_kernel(input int pat);
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 25; i++) k[c][i] = pix_t'($urandom);
        case (pat)
            1: for (int c = 0; c < 3; c++)
                   for (int i = 0; i < 25; i++) k[c][i] = 8'h55;
            2: begin
                for (int i = 0; i < 25; i++) begin
                    k[0][i] = pix_t'(i);
                    k[1][i] = pix_t'(24 - i);
                end
                shuffle(0);
            end
            3: begin
                for (int i = 0; i < 25; i++) begin
                    k[0][i] = (i < 12) ? 8'h00 : ((i == 12) ? 8'h80 : 8'hFF);
                    k[1][i] = 8'h33;
                    k[2][i] = 8'h10;
                end
                shuffle(0);
                k[1][$urandom_range(0, 24)] = pix_t'($urandom);
                k[2][$urandom_range(0, 24)] = 8'hFF;
            end
            4: for (int c = 0; c < 3; c++)
                   for (int i = 0; i < 25; i++) k[c][i] = pix_t'($urandom_range(0, 3));
            default: ;
        endcase
    endtask

    task automatic check_out(input exp_t e);
        n_cmp++;
        assert ({bus.tx_dv, bus.tx_hs, bus.tx_vs} === {e.dv, e.hs, e.vs}) else begin
            n_err++;
            $error("FAIL strobes observed=%b expected=%b",
                   {bus.tx_dv, bus.tx_hs, bus.tx_vs}, {e.dv, e.hs, e.vs});
        end
        if (e.dv) begin
            n_cmp++;
            assert (bus.tx_red === e.r) else begin
                n_err++;
                $error("FAIL tx_red observed=%h expected=%h", bus.tx_red, e.r);
            end
            n_cmp++;
            assert (bus.tx_green === e.g) else begin
                n_err++;
                $error("FAIL tx_green observed=%h expected=%h", bus.tx_green, e.g);
            end
            n_cmp++;
            assert (bus.tx_blue === e.b) else begin
                n_err++;
                $error("FAIL tx_blue observed=%h expected=%h", bus.tx_blue, e.b);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        n_cmp++;
        assert ({bus.tx_red, bus.tx_green, bus.tx_blue, bus.tx_dv, bus.tx_hs, bus.tx_vs} === '0)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=0", tag,
                   {bus.tx_red, bus.tx_green, bus.tx_blue, bus.tx_dv, bus.tx_hs, bus.tx_vs});
        end
    endtask

    // Drive one cycle; 'full' is the bench's own knowledge of whether the 5x5 window is populated.
    task automatic step(input logic dv, input logic hs, input logic vs, input logic full);
        exp_t e;
        bus.rx_dv = dv;
        bus.rx_hs = hs;
        bus.rx_vs = vs;
        for (int i = 0; i < 25; i++) begin
            bus.kernel_red[i*DATA_W +: DATA_W]   = k[0][i];
            bus.kernel_green[i*DATA_W +: DATA_W] = k[1][i];
            bus.kernel_blue[i*DATA_W +: DATA_W]  = k[2][i];
        end
        e.dv = dv;
        e.hs = hs;
        e.vs = vs;
        e.r  = full ? median_of(0) : k[0][12];
        e.g  = full ? median_of(1) : k[1][12];
        e.b  = full ? median_of(2) : k[2][12];
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        check_out(exp_q.pop_front());
    endtask

    task automatic prime_pipe();
        exp_q.delete();
        repeat (3) exp_q.push_back('0);
    endtask

    initial begin
        bus.kernel_red   = '0;
        bus.kernel_green = '0;
        bus.kernel_blue  = '0;
        bus.rx_dv        = 1'b0;
        bus.rx_hs        = 1'b0;
        bus.rx_vs        = 1'b0;
        gen_kernel(0);

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst = 1'b1;
        prime_pipe();

        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int y = 0; y < LINES; y++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            for (int x = 0; x < WIDTH; x++) begin
                gen_kernel((y == LINES - 1 && x >= 4) ? x - 3 : 0);
                step(1'b1, 1'b0, 1'b0, (x >= 4) && (y >= 4));
            end
            gen_kernel(0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Simultaneous hs and vs, then a burst interrupted by reset.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int x = 0; x < 6; x++) begin
            gen_kernel(0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        #2 rst = 1'b0;
        #1 check_zero("reset_async");
        bus.rx_dv = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        prime_pipe();
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int x = 0; x < 3; x++) begin
            gen_kernel(x + 2);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
